// File: rtl/pisa_alu_pkg.sv
// Opcode set and shared constants for the shared-ALU issue path.
// op_legal() marks which opcodes the ALU actually implements.
package pisa_alu_pkg;

    localparam int ALU_W = 32;
    localparam logic [3:0] IDLE_OP = 4'b1111;

    typedef enum logic [3:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        MUL = 4'b0010,
        AND = 4'b0100,
        OR  = 4'b0110,
        XOR = 4'b0111,
        SLL = 4'b1000,
        SRL = 4'b1001,
        SRA = 4'b1010
    } alu_op_e;

    function automatic logic op_legal(logic [3:0] op);
        case (op)
            ADD, SUB, MUL, AND, OR, XOR, SLL, SRL, SRA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr with wrap, grants first requester.
// ptr moves past the winner only when a grant is actually issued.
module alu_rr_arbiter #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    localparam int SW = IW + 1;

    logic [IW-1:0] ptr;

    always_comb begin
        logic [SW-1:0] s;
        logic [IW-1:0] j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = '0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + SW'(k);
            if (s >= SW'(N))
                s = s - SW'(N);
            j = s[IW-1:0];
            if (en && !any && req[j]) begin
                any    = 1'b1;
                idx    = j;
                gnt[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (any)
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters with round-robin issue
// and a credit-checked tagged response FIFO (issue-to-response latency 2).
module alu_issue_arbiter
    import pisa_alu_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int RSP_DEPTH = 2,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*4-1:0]     req_op,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    output logic [3:0]               alu_opcode,
    output logic [ALU_W-1:0]         alu_a,
    output logic [ALU_W-1:0]         alu_b,
    input  logic [ALU_W-1:0]         alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ALU_W-1:0]         rsp_data,
    output logic                     rsp_illegal
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);

    logic [3:0]       ops  [NUM_REQ];
    logic [ALU_W-1:0] opa  [NUM_REQ];
    logic [ALU_W-1:0] opb  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign ops[i] = req_op[i*4 +: 4];
        assign opa[i] = req_a[i*ALU_W +: ALU_W];
        assign opb[i] = req_b[i*ALU_W +: ALU_W];
    end

    logic [CW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [ID_W-1:0]  fifo_id   [RSP_DEPTH];
    logic [ALU_W-1:0] fifo_data [RSP_DEPTH];
    logic             fifo_ill  [RSP_DEPTH];

    logic             infl;
    logic             infl_ill;
    logic [ID_W-1:0]  infl_id;

    logic             pop;
    logic             push;
    logic             can_issue;
    logic             issue;
    logic [ID_W-1:0]  win;

    function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop  = rsp_valid & rsp_ready;
    assign push = infl;

    // Credit counts the in-flight op so its capture slot is always reserved.
    assign can_issue =
        (int'(count) + int'(infl) - int'(pop)) < RSP_DEPTH;

    alu_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (can_issue & ~rst),
        .gnt (req_ready),
        .idx (win),
        .any (issue)
    );

    always_comb begin
        alu_opcode = IDLE_OP;
        alu_a      = '0;
        alu_b      = '0;
        if (issue) begin
            alu_opcode = ops[win];
            alu_a      = opa[win];
            alu_b      = opb[win];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            infl     <= 1'b0;
            infl_id  <= '0;
            infl_ill <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            infl     <= issue;
            infl_id  <= issue ? win : '0;
            infl_ill <= issue & ~op_legal(ops[win]);
            if (push) begin
                fifo_id[wr_ptr]   <= infl_id;
                fifo_data[wr_ptr] <= infl_ill ? '0 : alu_result;
                fifo_ill[wr_ptr]  <= infl_ill;
                wr_ptr            <= nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rsp_valid   = (count != '0);
    assign rsp_id      = rsp_valid ? fifo_id[rd_ptr] : '0;
    assign rsp_data    = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_illegal = rsp_valid ? fifo_ill[rd_ptr] : 1'b0;

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

    a_count: assert property (@(posedge clk) disable iff (rst)
        int'(count) <= RSP_DEPTH);

    a_no_ovf: assert property (@(posedge clk) disable iff (rst)
        !(push && int'(count) == RSP_DEPTH));

    a_stable: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=>
            ($stable(rsp_id) && $stable(rsp_data) && $stable(rsp_illegal)));

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a registered 1-cycle ALU model.
module tb_alu_issue_arbiter;
    import pisa_alu_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*4-1:0] req_op = '0;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [3:0]     alu_opcode;
    logic [31:0]    alu_a;
    logic [31:0]    alu_b;
    logic [31:0]    alu_result = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_data;
    logic           rsp_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    alu_issue_arbiter #(
        .NUM_REQ   (N),
        .RSP_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_illegal (rsp_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(
        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ADD: return a + b;
            SUB: return a - b;
            MUL: return a * b;
            AND: return a & b;
            OR:  return a | b;
            XOR: return a ^ b;
            SLL: return a << b[4:0];
            SRL: return a >> b[4:0];
            SRA: return $signed(a) >>> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    always_ff @(posedge clk)
        alu_result <= alu_f(alu_opcode, alu_a, alu_b);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id,
                           input logic [31:0] data, input logic ill);
        check({tag, " valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " id"}, 32'(rsp_id), 32'(id));
        check({tag, " data"}, rsp_data, data);
        check({tag, " illegal"}, 32'(rsp_illegal), 32'(ill));
    endtask

    task automatic set_req(input int r, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[r]     = 1'b1;
        req_op[r*4 +: 4] = op;
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state, single ADD
        do_reset();
        rsp_ready = 1'b1;
        #1;
        check("rst rsp_valid", 32'(rsp_valid), 0);
        check("rst rsp_id", 32'(rsp_id), 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_illegal", 32'(rsp_illegal), 0);
        check("rst req_ready", 32'(req_ready), 0);
        check("idle opcode", 32'(alu_opcode), 32'hF);
        set_req(0, ADD, 5, 7);
        #1;
        check("t1 ready", 32'(req_ready), 32'h1);
        check("t1 alu_a", alu_a, 5);
        check("t1 alu_b", alu_b, 7);
        step();
        req_valid = '0;
        #1;
        check("t1 T+1 valid", 32'(rsp_valid), 0);
        step();
        #1;
        chk_rsp("t1 rsp", 0, 12, 0);
        step();
        #1;
        check("t1 drained", 32'(rsp_valid), 0);

        // 2: all four requesters, round robin from 0
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, SUB, 10, i);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = '0;
            #1;
            if (k < 8)
                check($sformatf("t2 ready%0d", k), 32'(req_ready),
                      32'(1 << (k % 4)));
            if (k >= 2)
                chk_rsp($sformatf("t2 rsp%0d", k), 2'((k - 2) % 4),
                        32'(10 - ((k - 2) % 4)), 0);
            else
                check("t2 early valid", 32'(rsp_valid), 0);
            step();
        end
        #1;
        check("t2 drained", 32'(rsp_valid), 0);

        // 3: back-pressure, credit limit of 2, resume on release
        rsp_ready = 1'b0;
        set_req(0, ADD, 200, 0);
        #1;
        check("t3 c0 ready", 32'(req_ready), 32'h1);
        step();
        set_req(0, ADD, 201, 0);
        #1;
        check("t3 c1 ready", 32'(req_ready), 32'h1);
        step();
        set_req(0, ADD, 202, 0);
        #1;
        check("t3 c2 ready", 32'(req_ready), 0);
        step();
        #1;
        check("t3 c3 ready", 32'(req_ready), 0);
        chk_rsp("t3 c3 held", 0, 200, 0);
        step();
        rsp_ready = 1'b1;
        #1;
        check("t3 c4 resume", 32'(req_ready), 32'h1);
        chk_rsp("t3 c4 rsp", 0, 200, 0);
        step();
        set_req(0, ADD, 203, 0);
        #1;
        check("t3 c5 ready", 32'(req_ready), 32'h1);
        chk_rsp("t3 c5 rsp", 0, 201, 0);
        step();
        req_valid = '0;
        #1;
        chk_rsp("t3 c6 rsp", 0, 202, 0);
        step();
        #1;
        chk_rsp("t3 c7 rsp", 0, 203, 0);
        step();
        #1;
        check("t3 drained", 32'(rsp_valid), 0);

        // 4: illegal opcode then SRA
        set_req(2, 4'b0011, 9, 3);
        #1;
        check("t4 ready ill", 32'(req_ready), 32'h4);
        step();
        set_req(2, SRA, 32'h8000_0000, 4);
        #1;
        check("t4 ready sra", 32'(req_ready), 32'h4);
        check("t4 alu op", 32'(alu_opcode), 32'hA);
        step();
        req_valid = '0;
        #1;
        chk_rsp("t4 ill rsp", 2, 0, 1);
        step();
        #1;
        chk_rsp("t4 sra rsp", 2, 32'hF800_0000, 0);
        step();

        // 5: MUL truncation, SLL shift masking; ptr=3 so req3 wins first
        set_req(1, MUL, 32'h0001_0000, 32'h0001_0000);
        set_req(3, SLL, 1, 33);
        #1;
        check("t5 ready c0", 32'(req_ready), 32'h8);
        step();
        req_valid[3] = 1'b0;
        #1;
        check("t5 ready c1", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        #1;
        chk_rsp("t5 sll rsp", 3, 2, 0);
        step();
        #1;
        chk_rsp("t5 mul rsp", 1, 0, 0);
        step();

        // 6: reset with work outstanding
        rsp_ready = 1'b0;
        set_req(0, ADD, 1, 1);
        #1;
        check("t6 c0 ready", 32'(req_ready), 32'h1);
        step();
        #1;
        check("t6 c1 ready", 32'(req_ready), 32'h1);
        step();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check("t6 ready in rst", 32'(req_ready), 0);
        step();
        rst = 1'b0;
        req_valid = '0;
        #1;
        check("t6 post valid", 32'(rsp_valid), 0);
        check("t6 post data", rsp_data, 0);
        for (int i = 0; i < N; i++) set_req(i, ADD, i, 1);
        rsp_ready = 1'b1;
        #1;
        check("t6 ptr zero", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check("t6 no stale", 32'(rsp_valid), 0);
        step();
        #1;
        chk_rsp("t6 fresh rsp", 0, 1, 0);
        step();
        #1;
        check("t6 drained", 32'(rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
